// File: rtl/mouse_pattern_gen.sv
// mouse_pattern_gen: boot-protocol style HID mouse report source.
// Emits {buttons, dx, dy, wheel} reports at REPORT_HZ over valid/ready.
// Optional build macro MOUSE_JITTER_EN adds LFSR-driven +/-1 jitter to
// the non-zero dx/dy components of pattern reports.
module mouse_pattern_gen #(
   parameter int CLK_HZ       = 27000000,
   parameter int REPORT_HZ    = 125,
   parameter int AXIS_W       = 8,
   parameter int NUM_PATTERNS = 4,
   parameter int STEP         = 4,
   parameter int SIDE_LEN     = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             pattern_enable,
   input  logic [$clog2(NUM_PATTERNS)-1:0]  pattern_select,
   input  logic                             report_ready,
   output logic                             report_valid,
   output logic [2:0]                       report_buttons,
   output logic signed [AXIS_W-1:0]         report_dx,
   output logic signed [AXIS_W-1:0]         report_dy,
   output logic signed [AXIS_W-1:0]         report_wheel,
   output logic                             overrun,
   output logic [1:0]                       seg_idx
);

   localparam int DIV   = CLK_HZ / REPORT_HZ;
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int SEL_W = $clog2(NUM_PATTERNS);
   localparam int CNT_W = (SIDE_LEN > 1) ? $clog2(SIDE_LEN) : 1;
   localparam logic signed [AXIS_W-1:0] STEP_P = AXIS_W'(STEP);
   localparam logic signed [AXIS_W-1:0] STEP_N = -STEP_P;

   if (DIV < 2) begin : g_bad_div
      $error("mouse_pattern_gen: CLK_HZ/REPORT_HZ must be at least 2");
   end
   if (NUM_PATTERNS < 4) begin : g_bad_np
      $error("mouse_pattern_gen: NUM_PATTERNS must be at least 4");
   end
   if (STEP > (2 ** (AXIS_W - 1)) - 1) begin : g_bad_step
      $error("mouse_pattern_gen: STEP does not fit the signed axis width");
   end
   if (SIDE_LEN < 1) begin : g_bad_side
      $error("mouse_pattern_gen: SIDE_LEN must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RUN      = 3'd1,
      S_PEND     = 3'd2,
      S_REL      = 3'd3,
      S_PEND_REL = 3'd4
   } state_t;

   state_t                   state_q, state_d;
   logic [DIV_W-1:0]         div_q, div_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [1:0]               seg_q, seg_d;
   logic [SEL_W-1:0]         sel_q;
   logic                     chg_q, chg_d;
   logic                     valid_q, valid_d;
   logic                     ovr_q, ovr_d;
   logic [2:0]               btn_q, btn_d;
   logic signed [AXIS_W-1:0] dx_q, dx_d, dy_q, dy_d, wh_q, wh_d;

   logic                     tick_s;
   logic                     change_s;
   logic                     hs_s;
   logic [1:0]               eff_seg_s;
   logic [2:0]               pat_btn_s;
   logic signed [AXIS_W-1:0] pat_dx_s, pat_dy_s, pat_wh_s;
   logic signed [AXIS_W-1:0] out_dx_s, out_dy_s;

   assign change_s = (pattern_select != sel_q);
   assign hs_s     = valid_q & report_ready;

   // Report-rate divider: free-runs outside IDLE, pulses tick on wrap.
   always_comb begin
      tick_s = 1'b0;
      div_d  = div_q;
      if (state_q == S_IDLE) begin
         div_d = '0;
      end else if (div_q == DIV_W'(DIV - 1)) begin
         div_d  = '0;
         tick_s = 1'b1;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   // Pattern table: report content for the selected pattern and segment.
   // A pattern change seen in RUN restarts from segment 0 immediately.
   always_comb begin
      eff_seg_s = (state_q == S_RUN && change_s) ? 2'd0 : seg_q;
      pat_btn_s = 3'b000;
      pat_dx_s  = '0;
      pat_dy_s  = '0;
      pat_wh_s  = '0;
      case (pattern_select)
         SEL_W'(0): begin
            case (eff_seg_s)
               2'd0:    pat_dx_s = STEP_P;
               2'd1:    pat_dy_s = STEP_P;
               2'd2:    pat_dx_s = STEP_N;
               default: pat_dy_s = STEP_N;
            endcase
         end
         SEL_W'(1): pat_dx_s  = eff_seg_s[0] ? STEP_N : STEP_P;
         SEL_W'(2): pat_btn_s = {2'b00, ~eff_seg_s[0]};
         SEL_W'(3): pat_wh_s  = eff_seg_s[1] ? {AXIS_W{1'b1}} : AXIS_W'(1);
         default:   pat_btn_s = 3'b000;
      endcase
   end

`ifdef MOUSE_JITTER_EN
   localparam logic signed [AXIS_W:0] MAX_EXT = (AXIS_W + 1)'((2 ** (AXIS_W - 1)) - 1);
   localparam logic signed [AXIS_W:0] MIN_EXT = -MAX_EXT;

   logic [15:0]       lfsr_q;
   logic signed [1:0] jit_s;
   logic              emit_s;

   function automatic logic signed [AXIS_W-1:0] sat_add(
      input logic signed [AXIS_W-1:0] v,
      input logic signed [1:0]        j
   );
      logic signed [AXIS_W:0] s;
      s = {v[AXIS_W-1], v} + {{(AXIS_W - 1){j[1]}}, j};
      if (s > MAX_EXT) begin
         s = MAX_EXT;
      end else if (s < MIN_EXT) begin
         s = MIN_EXT;
      end else begin
         s = s;
      end
      return s[AXIS_W-1:0];
   endfunction

   assign emit_s   = tick_s & ((state_q == S_RUN) | (state_q == S_REL));
   assign jit_s    = (lfsr_q[1:0] == 2'b01) ? 2'sb01 :
                     (lfsr_q[1:0] == 2'b10) ? 2'sb11 : 2'sb00;
   assign out_dx_s = (pat_dx_s != '0) ? sat_add(pat_dx_s, jit_s) : pat_dx_s;
   assign out_dy_s = (pat_dy_s != '0) ? sat_add(pat_dy_s, jit_s) : pat_dy_s;

   // Galois LFSR, advanced once for every report that is emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 16'hACE1;
      end else if (emit_s) begin
         lfsr_q <= (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      end
   end
`else
   assign out_dx_s = pat_dx_s;
   assign out_dy_s = pat_dy_s;
`endif

   // Control FSM: emit, hold until accepted, release cleanly on disable.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seg_d   = seg_q;
      chg_d   = chg_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      btn_d   = btn_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      wh_d    = wh_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            seg_d = 2'd0;
            chg_d = 1'b0;
            if (pattern_enable) begin
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            chg_d = 1'b0;
            if (change_s) begin
               cnt_d = '0;
               seg_d = 2'd0;
            end else begin
               cnt_d = cnt_q;
            end
            if (tick_s) begin
               valid_d = 1'b1;
               btn_d   = pat_btn_s;
               dx_d    = out_dx_s;
               dy_d    = out_dy_s;
               wh_d    = pat_wh_s;
               state_d = S_PEND;
            end else begin
               state_d = S_RUN;
            end
         end
         S_PEND: begin
            if (tick_s) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (change_s) begin
               chg_d = 1'b1;
            end else begin
               chg_d = chg_q;
            end
            if (hs_s) begin
               valid_d = 1'b0;
               chg_d   = 1'b0;
               if (chg_q || change_s) begin
                  cnt_d = '0;
                  seg_d = 2'd0;
               end else if (cnt_q == CNT_W'(SIDE_LEN - 1)) begin
                  cnt_d = '0;
                  seg_d = seg_q + 2'd1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               state_d = pattern_enable ? S_RUN : S_REL;
            end else begin
               state_d = S_PEND;
            end
         end
         S_REL: begin
            if (tick_s) begin
               valid_d = 1'b1;
               btn_d   = 3'b000;
               dx_d    = '0;
               dy_d    = '0;
               wh_d    = '0;
               state_d = S_PEND_REL;
            end else begin
               state_d = S_REL;
            end
         end
         S_PEND_REL: begin
            if (tick_s) begin
               ovr_d = 1'b1;
            end else begin
               ovr_d = ovr_q;
            end
            if (hs_s) begin
               valid_d = 1'b0;
               cnt_d   = '0;
               seg_d   = 2'd0;
               chg_d   = 1'b0;
               state_d = S_IDLE;
            end else begin
               state_d = S_PEND_REL;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State, divider, position and registered report outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         cnt_q   <= '0;
         seg_q   <= 2'd0;
         sel_q   <= '0;
         chg_q   <= 1'b0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         btn_q   <= 3'b000;
         dx_q    <= '0;
         dy_q    <= '0;
         wh_q    <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         cnt_q   <= cnt_d;
         seg_q   <= seg_d;
         sel_q   <= pattern_select;
         chg_q   <= chg_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         btn_q   <= btn_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         wh_q    <= wh_d;
      end
   end

   assign report_valid   = valid_q;
   assign report_buttons = btn_q;
   assign report_dx      = dx_q;
   assign report_dy      = dy_q;
   assign report_wheel   = wh_q;
   assign overrun        = ovr_q;
   assign seg_idx        = seg_q;

endmodule

// File: tb/tb_mouse_pattern_gen.sv
// Bench for mouse_pattern_gen: directed scenarios plus a report-sequence
// model checked on every accepted report and every back-pressured cycle.
module tb_mouse_pattern_gen;

   localparam int AXIS_W   = 8;
   localparam int SIDE_LEN = 2;
   localparam int STEP     = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        en    = 1'b0;
   logic        ready = 1'b1;
   logic [1:0]  sel   = 2'd0;
   logic        report_valid, overrun;
   logic [2:0]  report_buttons;
   logic [7:0]  report_dx, report_dy, report_wheel;
   logic [1:0]  seg_idx;

   mouse_pattern_gen #(
      .CLK_HZ(1000), .REPORT_HZ(100), .AXIS_W(AXIS_W),
      .NUM_PATTERNS(4), .STEP(STEP), .SIDE_LEN(SIDE_LEN)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pattern_enable(en), .pattern_select(sel),
      .report_ready(ready), .report_valid(report_valid),
      .report_buttons(report_buttons), .report_dx(report_dx),
      .report_dy(report_dy), .report_wheel(report_wheel),
      .overrun(overrun), .seg_idx(seg_idx)
   );

   // Requests from the directed sequence to the model.
   int rel_req = 0;
   int restart_req = 0;
   int restart_pat = 0;

   // Model state, owned by the monitor.
   int m_k = 0, m_pat = 0, m_phase = 0, m_rel_seen = 0, m_rst_seen = 0;
   logic m_pat_known = 1'b0, m_hold = 1'b0;
   logic [26:0] h_payload = '0;
   int hs_cnt = 0, mon_chk = 0, mon_fail = 0;
   logic [2:0] last_btn = '0;
   logic [7:0] last_dx = '0, last_dy = '0;
   logic [1:0] last_seg = '0;

   // The k-th report of a pattern run: segment = (k / SIDE_LEN) mod 4.
   function automatic logic [26:0] model_rep(int pat, int k);
      int s, b, x, y, w;
      s = (k / SIDE_LEN) % 4;
      b = 0; x = 0; y = 0; w = 0;
      if (pat == 0) begin
         if (s == 0) x = STEP;
         else if (s == 1) y = STEP;
         else if (s == 2) x = -STEP;
         else y = -STEP;
      end else if (pat == 1) begin
         x = (s % 2 == 0) ? STEP : -STEP;
      end else if (pat == 2) begin
         b = (s % 2 == 0) ? 1 : 0;
      end else if (pat == 3) begin
         w = (s < 2) ? 1 : -1;
      end
      return {3'(b), 8'(x), 8'(y), 8'(w)};
   endfunction

   // Monitor: hold stability, silence after release, and per-report model check.
   always @(negedge clk) begin
      logic [26:0] act, exp_v;
      int pat_v, c, f;
      c = 0; f = 0;
      act = {report_buttons, report_dx, report_dy, report_wheel};
      if (!rst_n) begin
         m_k <= 0; m_pat_known <= 1'b0; m_phase <= 0; m_hold <= 1'b0;
         m_rel_seen <= rel_req; m_rst_seen <= restart_req;
      end else begin
         if (m_hold) begin
            c++;
            if (!(report_valid && act == h_payload)) begin
               f++;
               $display("FAIL hold_stable: got valid=%0b payload=%h, required valid=1 payload=%h",
                        report_valid, act, h_payload);
            end
         end
         if (m_phase == 2) begin
            c++;
            if (report_valid) begin
               f++;
               $display("FAIL no_valid_after_release: got valid=1, required 0");
            end
         end
         m_hold    <= report_valid && !ready;
         h_payload <= act;
         if (report_valid && ready) begin
            pat_v = m_pat_known ? m_pat : int'(sel);
            exp_v = (m_phase == 1) ? 27'd0 : model_rep(pat_v, m_k);
            c++;
            if (act != exp_v) begin
               f++;
               $display("FAIL report_%0d: got %h, required %h", hs_cnt, act, exp_v);
            end
            if (m_phase == 0) begin
               c++;
               if (seg_idx != 2'((m_k / SIDE_LEN) % 4)) begin
                  f++;
                  $display("FAIL seg_idx_%0d: got %0d, required %0d", hs_cnt, seg_idx,
                           (m_k / SIDE_LEN) % 4);
               end
            end
            hs_cnt   <= hs_cnt + 1;
            last_btn <= report_buttons; last_dx <= report_dx;
            last_dy  <= report_dy;      last_seg <= seg_idx;
            m_pat_known <= 1'b1;
            m_pat <= pat_v;
            if (m_phase == 1) m_phase <= 2;
            else m_k <= m_k + 1;
            if (restart_req != m_rst_seen) begin
               m_k <= 0; m_pat <= restart_pat; m_rst_seen <= restart_req;
            end
            if (rel_req != m_rel_seen) begin
               m_phase <= 1; m_rel_seen <= rel_req;
            end
         end
      end
      mon_chk  <= mon_chk + c;
      mon_fail <= mon_fail + f;
   end

   int n_chk = 0, n_fail = 0, base = 0;

   task automatic dcheck(input string name, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic wait_hs(input int target);
      int c = 0;
      while (hs_cnt < target && c < 200) begin tick(1); c++; end
      if (hs_cnt < target) dcheck("wait_handshake_timeout", hs_cnt, target);
   endtask

   task automatic wait_valid();
      int c = 0;
      while (!report_valid && c < 60) begin tick(1); c++; end
      if (!report_valid) dcheck("wait_valid_timeout", 0, 1);
   endtask

   // Raise enable just after an edge and count edges from the sampling edge.
   task automatic enable_and_measure(input string name);
      int n = 0;
      en = 1'b1;
      while (!report_valid && n < 40) begin @(posedge clk); #1; n++; end
      dcheck(name, n - 1, 10);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; ready = 1'b1; sel = 2'd0;
      tick(3);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      tick(3);
      dcheck("reset_valid", report_valid, 0);
      dcheck("reset_overrun", overrun, 0);
      dcheck("reset_dx", report_dx, 0);
      dcheck("reset_buttons", report_buttons, 0);
      rst_n = 1'b1;
      tick(2);
      dcheck("idle_valid", report_valid, 0);
      dcheck("idle_seg", seg_idx, 0);

      // Square: one full lap of four segments.
      sel = 2'd0; base = hs_cnt;
      enable_and_measure("first_valid_latency");
      wait_hs(base + 1); dcheck("sq_first_dx", last_dx, 4);
      wait_hs(base + 5); dcheck("sq_seg2_dx", last_dx, 8'hFC);
      wait_hs(base + 7); dcheck("sq_seg3_dy", last_dy, 8'hFC);
      dcheck("sq_seg3_idx", last_seg, 3);
      wait_hs(base + 8);

      // Back-pressure: held report, overrun, no skipped position.
      do_reset();
      ready = 1'b0; base = hs_cnt;
      enable_and_measure("bp_latency");
      tick(25);
      dcheck("bp_overrun", overrun, 1);
      ready = 1'b1;
      wait_hs(base + 2);
      dcheck("bp_second_dx", last_dx, 4);
      dcheck("bp_second_seg", last_seg, 0);

      // Disable while a click is pending: that report, then one zero report.
      do_reset();
      sel = 2'd2; ready = 1'b0; base = hs_cnt;
      enable_and_measure("click_latency");
      dcheck("click_pending_left", report_buttons, 1);
      en = 1'b0; rel_req++; ready = 1'b1;
      wait_hs(base + 1); dcheck("click_accepted_left", last_btn, 1);
      wait_hs(base + 2); dcheck("release_buttons", last_btn, 0);
      dcheck("release_dx", last_dx, 0);
      tick(30);
      dcheck("release_idle_valid", report_valid, 0);
      dcheck("release_idle_seg", seg_idx, 0);

      // Pattern change while the second zigzag report is pending.
      do_reset();
      sel = 2'd1; base = hs_cnt;
      enable_and_measure("zigzag_latency");
      wait_hs(base + 1);
      ready = 1'b0;
      wait_valid();
      restart_pat = 0; restart_req++; sel = 2'd0;
      tick(2);
      ready = 1'b1;
      wait_hs(base + 2); dcheck("chg_pending_dx", last_dx, 4);
      wait_hs(base + 3); dcheck("chg_restart_seg", last_seg, 0);
      dcheck("chg_restart_dy", last_dy, 0);

      // Asynchronous reset while a report is pending.
      do_reset();
      ready = 1'b0; en = 1'b1;
      wait_valid();
      tick(12);
      dcheck("pre_reset_overrun", overrun, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      dcheck("async_rst_valid", report_valid, 0);
      dcheck("async_rst_overrun", overrun, 0);
      dcheck("async_rst_dx", report_dx, 0);
      @(posedge clk); #1;
      ready = 1'b1; rst_n = 1'b1; base = hs_cnt;
      enable_and_measure("post_reset_latency");
      wait_hs(base + 1); dcheck("post_reset_dx", last_dx, 4);
      tick(2);

      n_chk  += mon_chk;
      n_fail += mon_fail;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
